ntt_bitrev_reorder: RTL

NTT_BITREV_REORDER -- requirements
Module: ntt_bitrev_reorder

---
 rtl/ntt_bitrev_reorder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ntt_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed-order NTT words in, natural-order words out.
// Define NTT_REORDER_MODRED_EN to apply a single conditional MODULUS subtraction on output.
`timescale 1ns/1ps
module ntt_bitrev_reorder #(
    parameter int unsigned W       = 32,
    parameter int unsigned N       = 8,
    parameter int unsigned MODULUS = 7681
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int unsigned AW = $clog2(N);
    localparam logic [AW-1:0] LastIdx = AW'(N - 1);

    if ((N < 2) || ((N & (N - 1)) != 0) || (MODULUS == 0)) begin : gen_bad_param
        $error("ntt_bitrev_reorder: N must be a power of two >= 2 and MODULUS nonzero");
    end

    typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_state_e;

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic          wptr_q, wptr_d;
    logic          rptr_q, rptr_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [W-1:0]  mem_q [2*N];

    logic          wr_en;
    logic          load_en;
    logic          drain_done;
    logic [W-1:0]  rd_word;
    logic [W-1:0]  out_word;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = a[AW-1-b];
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= StEmpty;
            bank_q[1] <= StEmpty;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            if (load_en) begin
                out_valid <= 1'b1;
                out_data  <= out_word;
                out_index <= rcnt_q;
                out_last  <= (rcnt_q == LastIdx);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wptr_q, bitrev(wcnt_q)}] <= in_data;
        end
    end

    // Next-state logic
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;

        if (bank_q[rptr_q] == StFull) begin
            bank_d[rptr_q] = StDraining;
        end
        if (load_en) begin
            rcnt_d = rcnt_q + AW'(1);
            if (drain_done) begin
                bank_d[rptr_q] = StEmpty;
                rptr_d         = ~rptr_q;
                rcnt_d         = '0;
                // Hand straight over to a waiting full bank so frames stream without a bubble
                if (bank_q[~rptr_q] == StFull) begin
                    bank_d[~rptr_q] = StDraining;
                end
            end
        end

        // Write side last: a bank released by the final read this cycle may start refilling
        if (wr_en) begin
            wcnt_d = wcnt_q + AW'(1);
            if (wcnt_q == LastIdx) begin
                bank_d[wptr_q] = StFull;
                wptr_d         = ~wptr_q;
                wcnt_d         = '0;
            end else begin
                bank_d[wptr_q] = StFilling;
            end
        end
    end

    // Output / control decode
    always_comb begin
        load_en    = (!out_valid || out_ready) && (bank_q[rptr_q] == StDraining);
        drain_done = load_en && (rcnt_q == LastIdx);
        in_ready   = (bank_q[wptr_q] == StEmpty) || (bank_q[wptr_q] == StFilling) ||
                     ((wptr_q == rptr_q) && drain_done);
        wr_en      = in_valid && in_ready;
        rd_word    = mem_q[{rptr_q, rcnt_q}];
`ifdef NTT_REORDER_MODRED_EN
        out_word   = (rd_word >= W'(MODULUS)) ? (rd_word - W'(MODULUS)) : rd_word;
`else
        out_word   = rd_word;
`endif
    end

endmodule
